// File: rtl/core_seqctl.sv
// Machine-cycle / T-state sequencer for an 8085-style datapath: walks M1..M5 and
// T1..T6 from the decoded info word and drives datapath enables and bus strobes.
module core_seqctl #(
  parameter int IENBSIZE = 7,
  parameter int INSTSIZE = 17,
  parameter int INFO_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                halt,
  output logic [2:0]          mcyc,
  output logic [2:0]          tst
);

  localparam int B_RRD = 0, B_RWR = 1, B_COD = 2, B_EXT = 3, B_PC = 4, B_PD = 5, B_NXT = 6;
  localparam int I_GO6 = 0, I_DAD = 1, I_HLT = 2, I_DIO = 3;
  localparam int I_CYC = 4, I_WR = 8, I_DP = 12;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T1   = 4'd1;
  localparam logic [3:0] S_T2   = 4'd2;
  localparam logic [3:0] S_TW   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]          state, state_nx;
  logic [2:0]          mcyc_q, mcyc_nx, mcyc_end;
  logic [INSTSIZE-1:0] snap;
  logic [INFO_CYC-1:0] therm, wmap, dmap;
  logic                cur_w, cur_d, adv, in_bus, is_mn, is_write;
  logic                unused_info;

  assign therm = snap[I_CYC +: INFO_CYC];
  assign wmap  = snap[I_WR  +: INFO_CYC];
  assign dmap  = snap[I_DP  +: INFO_CYC];
  assign unused_info = ^{snap[I_DAD], snap[INSTSIZE-1]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cur_w = 1'b0;
    cur_d = 1'b0;
    adv   = 1'b0;
    case (mcyc_q)
      3'd1: adv = therm[0];
      3'd2: begin cur_w = wmap[0]; cur_d = dmap[0]; adv = therm[1]; end
      3'd3: begin cur_w = wmap[1]; cur_d = dmap[1]; adv = therm[2]; end
      3'd4: begin cur_w = wmap[2]; cur_d = dmap[2]; adv = therm[3]; end
      3'd5: begin cur_w = wmap[3]; cur_d = dmap[3]; end
      default: ;
    endcase
  end

  assign mcyc_end = adv ? mcyc_q + 3'd1 : 3'd1;
  assign is_mn    = (mcyc_q != 3'd1);
  assign is_write = is_mn && cur_w;
  assign in_bus   = (state == S_T1) || (state == S_T2) || (state == S_TW) || (state == S_T3);

  always_comb begin
    state_nx = state;
    mcyc_nx  = mcyc_q;
    case (state)
      S_RST: begin state_nx = S_T1; mcyc_nx = 3'd1; end
      S_T1:  state_nx = S_T2;
      S_T2, S_TW: state_nx = ready ? S_T3 : S_TW;
      S_T3: begin
        if (!is_mn) state_nx = S_T4;
        else begin state_nx = S_T1; mcyc_nx = mcyc_end; end
      end
      S_T4: begin
        if (snap[I_HLT])      state_nx = S_HALT;
        else if (snap[I_GO6]) state_nx = S_T5;
        else begin state_nx = S_T1; mcyc_nx = mcyc_end; end
      end
      S_T5: state_nx = S_T6;
      S_T6: begin state_nx = S_T1; mcyc_nx = mcyc_end; end
      S_HALT: state_nx = S_HALT;
      default: begin state_nx = S_RST; mcyc_nx = 3'd1; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state  <= S_RST;
      mcyc_q <= 3'd1;
      snap   <= '0;
    end else begin
      state  <= state_nx;
      mcyc_q <= mcyc_nx;
      if (state == S_T3 && !is_mn) snap <= chk_i;
    end
  end

  always_comb begin
    ienb = '0;
    ale  = 1'b0;
    rd_  = 1'b1;
    wr_  = 1'b1;
    io_m = in_bus && (mcyc_q == 3'd3) && snap[I_DIO];
    if (in_bus && is_mn && cur_d)                       ienb[B_PD]  = 1'b1;
    if (in_bus && (mcyc_q == 3'd2 || mcyc_q == 3'd4))   ienb[B_NXT] = 1'b1;
    case (state)
      S_T1: ale = 1'b1;
      S_T2, S_TW, S_T3: begin
        rd_ = is_write;
        wr_ = !is_write;
        if (is_write) ienb[B_RRD] = 1'b1;
        // Address increments only on code fetches: M1, or a read not steered by the data pointer.
        if (state == S_T2 && !is_write && (!is_mn || !cur_d)) ienb[B_PC] = 1'b1;
        if (state == S_T3) begin
          if (!is_mn)         ienb[B_COD] = 1'b1;
          else if (!is_write) ienb[B_RWR] = 1'b1;
        end
      end
      S_T4: if (!snap[I_HLT] && !snap[I_GO6] && therm == '0) ienb[B_RWR] = 1'b1;
      S_T6: begin ienb[B_EXT] = 1'b1; ienb[B_RWR] = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    tst = 3'd1;
    case (state)
      S_T2, S_TW: tst = 3'd2;
      S_T3:       tst = 3'd3;
      S_T4:       tst = 3'd4;
      S_T5:       tst = 3'd5;
      S_T6:       tst = 3'd6;
      default:    tst = 3'd1;
    endcase
  end

  assign halt = (state == S_HALT);
  assign mcyc = mcyc_q;

endmodule

// File: tb/tb_core_seqctl.sv
// Self-checking bench for core_seqctl: per-clock expected outputs are queued as
// stimulus is driven and compared just after the following rising edge.
module tb_core_seqctl;

  localparam logic [6:0] RRD = 7'h01, RWR = 7'h02, COD = 7'h04, EXT = 7'h08;
  localparam logic [6:0] PC  = 7'h10, PD  = 7'h20, NXT = 7'h40;

  localparam logic [16:0] I_NOP = 17'h00000;
  localparam logic [16:0] I_LXI = 17'h00030;
  localparam logic [16:0] I_MOV = 17'h01110;
  localparam logic [16:0] I_INX = 17'h00001;
  localparam logic [16:0] I_HLT = 17'h00004;
  localparam logic [16:0] I_IN  = 17'h00038;
  localparam logic [16:0] I_M5  = 17'h000F0;

  typedef struct {
    bit          rst;
    logic [16:0] chk;
    bit          rdy;
    int          m;
    int          t;
    logic [6:0]  ie;
    bit          a, r, w, io, h;
    bit          cm;
  } vec_t;

  logic        clk, rst_, ready;
  logic [16:0] chk_i;
  logic [6:0]  ienb;
  logic        ale, rd_, wr_, io_m, halt;
  logic [2:0]  mcyc, tst;

  int   ncheck = 0;
  int   nfail  = 0;
  vec_t tbl[$];
  vec_t sb[$];

  core_seqctl dut (
    .clk(clk), .rst_(rst_), .chk_i(chk_i), .ready(ready),
    .ienb(ienb), .ale(ale), .rd_(rd_), .wr_(wr_), .io_m(io_m),
    .halt(halt), .mcyc(mcyc), .tst(tst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t row(logic [16:0] chk, bit rdy, int m, int t, logic [6:0] ie,
                               bit a, bit r, bit w, bit io);
    vec_t v;
    v.rst = 1'b1; v.chk = chk; v.rdy = rdy; v.m = m; v.t = t; v.ie = ie;
    v.a = a; v.r = r; v.w = w; v.io = io; v.h = 1'b0; v.cm = 1'b1;
    return v;
  endfunction

  function automatic vec_t rst_row();
    vec_t v;
    v = row(I_NOP, 1'b1, 1, 1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    v.rst = 1'b0;
    return v;
  endfunction

  function automatic vec_t halt_row();
    vec_t v;
    v = row(I_HLT, 1'b1, 1, 1, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    v.h  = 1'b1;
    v.cm = 1'b0;
    return v;
  endfunction

  // M1 T1..T3 of any instruction: ALE, then a PC_ fetch pulse, then opcode load.
  task automatic add_fetch(input logic [16:0] chk);
    tbl.push_back(row(chk, 1, 1, 1, 7'h00, 1, 1, 1, 0));
    tbl.push_back(row(chk, 1, 1, 2, PC,    0, 0, 1, 0));
    tbl.push_back(row(chk, 1, 1, 3, COD,   0, 0, 1, 0));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst_  = v.rst;
    chk_i = v.chk;
    ready = v.rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.cm) begin
      check({tag, ".mcyc"}, 32'(mcyc), 32'(e.m));
      check({tag, ".tst"},  32'(tst),  32'(e.t));
    end
    check({tag, ".ienb"}, 32'(ienb), 32'(e.ie));
    check({tag, ".ale"},  32'(ale),  32'(e.a));
    check({tag, ".rd_"},  32'(rd_),  32'(e.r));
    check({tag, ".wr_"},  32'(wr_),  32'(e.w));
    check({tag, ".io_m"}, 32'(io_m), 32'(e.io));
    check({tag, ".halt"}, 32'(halt), 32'(e.h));
  endtask

  initial begin
    rst_  = 1'b0;
    chk_i = '0;
    ready = 1'b1;

    // Reset, then NOP: T1..T4 and back to M1 T1.
    tbl.push_back(rst_row());
    add_fetch(I_NOP);
    tbl.push_back(row(I_NOP, 1, 1, 4, RWR, 0, 1, 1, 0));
    // LXI: two code-read machine cycles after the fetch.
    add_fetch(I_LXI);
    tbl.push_back(row(I_LXI, 1, 1, 4, 7'h00,     0, 1, 1, 0));
    tbl.push_back(row(I_LXI, 1, 2, 1, NXT,       1, 1, 1, 0));
    tbl.push_back(row(I_LXI, 1, 2, 2, NXT | PC,  0, 0, 1, 0));
    tbl.push_back(row(I_LXI, 1, 2, 3, NXT | RWR, 0, 0, 1, 0));
    tbl.push_back(row(I_LXI, 1, 3, 1, 7'h00,     1, 1, 1, 0));
    tbl.push_back(row(I_LXI, 1, 3, 2, PC,        0, 0, 1, 0));
    tbl.push_back(row(I_LXI, 1, 3, 3, RWR,       0, 0, 1, 0));
    // MOV M,r: one memory write through the data pointer.
    add_fetch(I_MOV);
    tbl.push_back(row(I_MOV, 1, 1, 4, 7'h00,          0, 1, 1, 0));
    tbl.push_back(row(I_MOV, 1, 2, 1, PD | NXT,       1, 1, 1, 0));
    tbl.push_back(row(I_MOV, 1, 2, 2, PD | NXT | RRD, 0, 1, 0, 0));
    tbl.push_back(row(I_MOV, 1, 2, 3, PD | NXT | RRD, 0, 1, 0, 0));
    // INX: six-state M1 with register-pair update in T6.
    add_fetch(I_INX);
    tbl.push_back(row(I_INX, 1, 1, 4, 7'h00,     0, 1, 1, 0));
    tbl.push_back(row(I_INX, 1, 1, 5, 7'h00,     0, 1, 1, 0));
    tbl.push_back(row(I_INX, 1, 1, 6, EXT | RWR, 0, 1, 1, 0));
    // NOP with two wait states in M1.
    tbl.push_back(row(I_NOP, 1, 1, 1, 7'h00, 1, 1, 1, 0));
    tbl.push_back(row(I_NOP, 1, 1, 2, PC,    0, 0, 1, 0));
    tbl.push_back(row(I_NOP, 0, 1, 2, 7'h00, 0, 0, 1, 0));
    tbl.push_back(row(I_NOP, 0, 1, 2, 7'h00, 0, 0, 1, 0));
    tbl.push_back(row(I_NOP, 1, 1, 3, COD,   0, 0, 1, 0));
    tbl.push_back(row(I_NOP, 1, 1, 4, RWR,   0, 1, 1, 0));
    // HLT: halted for 20 clocks, left only through reset.
    add_fetch(I_HLT);
    tbl.push_back(row(I_HLT, 1, 1, 4, 7'h00, 0, 1, 1, 0));
    for (int i = 0; i < 20; i++) tbl.push_back(halt_row());
    tbl.push_back(rst_row());
    tbl.push_back(row(I_NOP, 1, 1, 1, 7'h00, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Reset taken while sitting in TW aborts straight to the reset state.
    apply(rst_row(),                                   "twr0");
    apply(row(I_NOP, 1, 1, 1, 7'h00, 1, 1, 1, 0),     "twr1");
    apply(row(I_NOP, 1, 1, 2, PC,    0, 0, 1, 0),     "twr2");
    apply(row(I_NOP, 0, 1, 2, 7'h00, 0, 0, 1, 0),     "twr3");
    apply(rst_row(),                                   "twr4");
    apply(row(I_NOP, 0, 1, 1, 7'h00, 1, 1, 1, 0),     "twr5");

    // IN port: io_m only across M3 T1..T3.
    apply(rst_row(), "in0");
    apply(row(I_IN, 1, 1, 1, 7'h00,     1, 1, 1, 0), "in1");
    apply(row(I_IN, 1, 1, 2, PC,        0, 0, 1, 0), "in2");
    apply(row(I_IN, 1, 1, 3, COD,       0, 0, 1, 0), "in3");
    apply(row(I_IN, 1, 1, 4, 7'h00,     0, 1, 1, 0), "in4");
    apply(row(I_IN, 1, 2, 1, NXT,       1, 1, 1, 0), "in5");
    apply(row(I_IN, 1, 2, 2, NXT | PC,  0, 0, 1, 0), "in6");
    apply(row(I_IN, 1, 2, 3, NXT | RWR, 0, 0, 1, 0), "in7");
    apply(row(I_IN, 1, 3, 1, 7'h00,     1, 1, 1, 1), "in8");
    apply(row(I_IN, 1, 3, 2, PC,        0, 0, 1, 1), "in9");
    apply(row(I_IN, 1, 3, 3, RWR,       0, 0, 1, 1), "in10");
    apply(row(I_IN, 1, 1, 1, 7'h00,     1, 1, 1, 0), "in11");

    // Full thermometer: M1..M5 then wrap to M1, never past 5.
    apply(rst_row(), "m5r");
    apply(row(I_M5, 1, 1, 1, 7'h00, 1, 1, 1, 0), "m5f1");
    apply(row(I_M5, 1, 1, 2, PC,    0, 0, 1, 0), "m5f2");
    apply(row(I_M5, 1, 1, 3, COD,   0, 0, 1, 0), "m5f3");
    apply(row(I_M5, 1, 1, 4, 7'h00, 0, 1, 1, 0), "m5f4");
    for (int m = 2; m <= 5; m++) begin
      logic [6:0] nx;
      nx = (m == 2 || m == 4) ? NXT : 7'h00;
      apply(row(I_M5, 1, m, 1, nx,       1, 1, 1, 0), $sformatf("m5_%0d_1", m));
      apply(row(I_M5, 1, m, 2, nx | PC,  0, 0, 1, 0), $sformatf("m5_%0d_2", m));
      apply(row(I_M5, 1, m, 3, nx | RWR, 0, 0, 1, 0), $sformatf("m5_%0d_3", m));
    end
    apply(row(I_M5, 1, 1, 1, 7'h00, 1, 1, 1, 0), "m5wrap");

    $display("TB_RESULT checks=%0d failures=%0d", ncheck, nfail);
    $finish;
  end

endmodule
